// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART-fed byte loader with command FSM and fall-through FIFO
module prog_loader #(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       byte_done,
   output logic [7:0] data_out,
   output logic       mode,
   output logic       en,
   output logic       fifo_full,
   output logic       fifo_empty,
   output logic       err,
   output logic       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0]    CMD_PROG   = 8'h50;
   localparam logic [7:0]    CMD_VERIFY = 8'h56;
   localparam logic [7:0]    CMD_STOP   = 8'h53;
   localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT_CYCLES);
   localparam logic [AW:0]   OCC_FULL   = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      GET_LEN,
      LOAD,
      DRAIN,
      VERIFY
   } state_t;

   state_t        state, state_n;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   occ, occ_n;
   logic [8:0]    count, count_n;
   logic [TW-1:0] tmo, tmo_n;
   logic          err_n, mode_n, en_n, busy_n;
   logic          push_req, push, pop, flush;

   // status and head byte decoded straight from the FIFO registers
   assign fifo_empty = (occ == '0);
   assign fifo_full  = (occ == OCC_FULL);
   assign data_out   = mem[rd_ptr];

   // next-state, FIFO control and next registered-output decode
   always_comb begin
      state_n  = state;
      count_n  = count;
      tmo_n    = tmo;
      err_n    = err;
      flush    = 1'b0;
      push_req = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      occ_n    = occ;
      mode_n   = 1'b0;
      en_n     = 1'b0;
      busy_n   = 1'b0;

      // any received byte restarts the idle-gap measurement
      if (rx_valid) begin
         tmo_n = '0;
      end

      case (state)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == CMD_PROG) begin
                  state_n = GET_LEN;
                  err_n   = 1'b0;
               end else if (rx_data == CMD_VERIFY) begin
                  state_n = VERIFY;
                  err_n   = 1'b0;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         GET_LEN: begin
            if (rx_valid) begin
               // a length byte of zero stands for a full 256-byte block
               count_n = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
               tmo_n   = '0;
               state_n = LOAD;
            end
         end
         LOAD: begin
            if (tmo == TMO_LIMIT) begin
               // sender went quiet: abandon the block and everything buffered
               err_n   = 1'b1;
               flush   = 1'b1;
               tmo_n   = '0;
               state_n = IDLE;
            end else if (rx_valid) begin
               push_req = 1'b1;
               count_n  = count - 9'd1;
               if (count == 9'd1) begin
                  state_n = DRAIN;
               end
            end else begin
               tmo_n = tmo + TW'(1);
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_n = IDLE;
            end
         end
         VERIFY: begin
            if (rx_valid && (rx_data == CMD_STOP)) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // a pop frees a slot in the same cycle, so push at full succeeds alongside it
      pop  = byte_done && !fifo_empty && !flush;
      push = push_req && (!fifo_full || pop);
      if (push_req && fifo_full && !pop) begin
         err_n = 1'b1;
      end

      if (flush) begin
         occ_n = '0;
      end else if (push && !pop) begin
         occ_n = occ + (AW+1)'(1);
      end else if (pop && !push) begin
         occ_n = occ - (AW+1)'(1);
      end

      // outputs are registered, so they are decoded from the state being entered
      busy_n = (state_n != IDLE);
      mode_n = (state_n == LOAD) || (state_n == DRAIN);
      if (state_n == VERIFY) begin
         en_n = 1'b1;
      end else if (mode_n) begin
         en_n = (occ_n != '0);
      end
   end

   // state, pointers, counters and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         count  <= '0;
         tmo    <= '0;
         mode   <= 1'b0;
         en     <= 1'b0;
         err    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         tmo   <= tmo_n;
         occ   <= occ_n;
         mode  <= mode_n;
         en    <= en_n;
         err   <= err_n;
         busy  <= busy_n;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
         end
      end
   end

   // FIFO storage; contents are qualified by occupancy so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= rx_data;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized bench for prog_loader against a queue-based model
module tb_prog_loader;

   localparam int DEPTH = 16;
   localparam int TMO   = 100;

   localparam int P_IDLE   = 0;
   localparam int P_LEN    = 1;
   localparam int P_LOAD   = 2;
   localparam int P_DRAIN  = 3;
   localparam int P_VERIFY = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       byte_done = 1'b0;
   logic [7:0] data_out;
   logic       mode, en, fifo_full, fifo_empty, err, busy;

   prog_loader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .byte_done  (byte_done),
      .data_out   (data_out),
      .mode       (mode),
      .en         (en),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: buffered bytes, session phase, bytes still owed, quiet-cycle count
   logic [7:0] mq[$];
   int         ph    = P_IDLE;
   int         rem   = 0;
   int         quiet = 0;
   bit         merr  = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit rv, input logic [7:0] rd, input bit bd);
      bit had_bytes;
      bit take_pop;
      bit want_push;
      bit drop_all;
      if (!r) begin
         mq.delete();
         ph    = P_IDLE;
         rem   = 0;
         quiet = 0;
         merr  = 1'b0;
         return;
      end
      had_bytes = (mq.size() > 0);
      take_pop  = bd && had_bytes;
      want_push = 1'b0;
      drop_all  = 1'b0;
      case (ph)
         P_IDLE: if (rv) begin
            if (rd == 8'h50) begin ph = P_LEN; merr = 1'b0; end
            else if (rd == 8'h56) begin ph = P_VERIFY; merr = 1'b0; end
            else merr = 1'b1;
         end
         P_LEN: if (rv) begin
            rem   = (rd == 8'h00) ? 256 : int'(rd);
            quiet = 0;
            ph    = P_LOAD;
         end
         P_LOAD: begin
            if (quiet == TMO) begin
               merr = 1'b1; drop_all = 1'b1; quiet = 0; ph = P_IDLE;
            end else if (rv) begin
               want_push = 1'b1;
               rem--;
               quiet = 0;
               if (rem == 0) ph = P_DRAIN;
            end else begin
               quiet++;
            end
         end
         P_DRAIN: if (!had_bytes) ph = P_IDLE;
         P_VERIFY: if (rv && rd == 8'h53) ph = P_IDLE;
         default: ph = P_IDLE;
      endcase
      if (drop_all) begin
         mq.delete();
      end else begin
         if (take_pop) void'(mq.pop_front());
         if (want_push) begin
            if (mq.size() < DEPTH) mq.push_back(rd);
            else merr = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      bit prog;
      prog = (ph == P_LOAD) || (ph == P_DRAIN);
      check_val("busy",  busy,       (ph != P_IDLE));
      check_val("mode",  mode,       prog);
      check_val("en",    en,         (ph == P_VERIFY) || (prog && mq.size() > 0));
      check_val("err",   err,        merr);
      check_val("empty", fifo_empty, (mq.size() == 0));
      check_val("full",  fifo_full,  (mq.size() == DEPTH));
      if (mq.size() > 0) check_val("data_out", data_out, mq[0]);
   endtask

   task automatic tick(input bit r, input bit rv, input logic [7:0] rd, input bit bd);
      rst       = r;
      rx_valid  = rv;
      rx_data   = rd;
      byte_done = bd;
      @(posedge clk);
      model_step(r, rv, rd, bd);
      @(negedge clk);
      compare_all();
   endtask

   task automatic send(input logic [7:0] b);
      tick(1'b1, 1'b1, b, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b1, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic pop1();
      tick(1'b1, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      logic [7:0] exp032 [3];
      int         pops;
      int         guard;
      int         len, rxp, bdp, sent, sel;
      logic [7:0] b;

      exp032[0] = 8'hA1; exp032[1] = 8'hB2; exp032[2] = 8'hC3;

      // reset state
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      check_val("rst_empty", fifo_empty, 1);
      check_val("rst_full",  fifo_full,  0);
      check_val("rst_busy",  busy,       0);
      check_val("rst_en",    en,         0);
      idle(2);

      // verify session, stop, then an unknown command
      send(8'h56);
      check_val("v_mode", mode, 0);
      check_val("v_en",   en,   1);
      check_val("v_busy", busy, 1);
      send(8'h11);
      send(8'h53);
      check_val("v_stop_busy", busy, 0);
      check_val("v_stop_en",   en,   0);
      send(8'h41);
      check_val("bad_cmd_err", err, 1);

      // three-byte block drained in order
      send(8'h50); send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3);
      check_val("t032_clr_err", err, 0);
      idle(2);
      for (int k = 0; k < 3; k++) begin
         check_val("t032_head", data_out, exp032[k]);
         pop1();
         if (k == 2) begin
            check_val("t032_en_drop", en,   0);
            check_val("t032_draining", busy, 1);
            idle(1);
            check_val("t032_idle", busy, 0);
         end else begin
            idle(1);
         end
      end

      // 256-byte block paced so the FIFO never overflows
      send(8'h50); send(8'h00);
      pops = 0;
      for (int i = 0; i < 256; i++) begin
         for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
               if (!fifo_empty) pops++;
               check_val("t033_order", data_out, 8'(i) ^ 8'h5A);
            end
            tick(1'b1, (c == 0), 8'(i) ^ 8'h5A, (c == 3));
         end
      end
      idle(2);
      check_val("t033_err",  err,  0);
      check_val("t033_pops", pops, 256);
      check_val("t033_idle", busy, 0);

      // 20 bytes into a 16-deep FIFO with no consumer
      send(8'h50); send(8'h14);
      for (int i = 0; i < 20; i++) send(8'h30 + 8'(i));
      check_val("t034_full",  fifo_full, 1);
      check_val("t034_err",   err,       1);
      check_val("t034_drain", mode,      1);
      for (int i = 0; i < 16; i++) begin
         check_val("t034_order", data_out, 8'h30 + 8'(i));
         pop1();
      end
      check_val("t034_empty16", fifo_empty, 1);
      idle(1);
      check_val("t034_idle", busy, 0);

      // sender stalls mid-block
      send(8'h50); send(8'h05); send(8'hAA); send(8'hBB);
      idle(50);
      check_val("t035_still_loading", busy, 1);
      guard = 0;
      while (busy && guard < 200) begin
         idle(1);
         guard++;
      end
      check_val("t035_bounded", (guard < 200), 1);
      check_val("t035_err",   err,        1);
      check_val("t035_empty", fifo_empty, 1);

      // reset with 8 bytes buffered
      send(8'h50); send(8'h0A);
      for (int i = 0; i < 8; i++) send(8'(i) + 8'h70);
      check_val("t037_pre_en", en, 1);
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      check_val("t037_empty", fifo_empty, 1);
      check_val("t037_en",    en,         0);
      check_val("t037_idle",  busy,       0);
      idle(3);
      check_val("t037_en_quiet", en, 0);

      // randomized sessions
      for (int it = 0; it < 40; it++) begin
         if (ph != P_IDLE) tick(1'b0, 1'b0, 8'h00, 1'b0);
         sel = $urandom_range(0, 9);
         if (sel < 6) begin
            len = $urandom_range(1, 40);
            rxp = $urandom_range(30, 100);
            bdp = $urandom_range(0, 100);
            send(8'h50); send(8'(len));
            sent = 0; guard = 0;
            while (sent < len && guard < 5000) begin
               bit rv;
               rv = ($urandom_range(0, 99) < rxp);
               tick(1'b1, rv, 8'($urandom), ($urandom_range(0, 99) < bdp));
               if (rv) sent++;
               guard++;
            end
            guard = 0;
            while (ph != P_IDLE && guard < 3000) begin
               tick(1'b1, ($urandom_range(0, 7) == 0), 8'($urandom),
                    ($urandom_range(0, 99) < ((bdp < 20) ? 20 : bdp)));
               guard++;
            end
         end else if (sel < 8) begin
            send(8'h56);
            repeat ($urandom_range(0, 5)) begin
               b = 8'($urandom);
               if (b == 8'h53) b = 8'h54;
               tick(1'b1, 1'($urandom), b, 1'($urandom));
            end
            send(8'h53);
         end else if (sel == 8) begin
            b = 8'($urandom);
            if (b == 8'h50 || b == 8'h56) b = 8'h41;
            send(b);
         end else begin
            send(8'h50); send(8'($urandom_range(5, 30)));
            repeat ($urandom_range(1, 6)) send(8'($urandom));
            tick(1'b0, 1'b0, 8'h00, 1'b0);
            idle(1);
         end
         idle($urandom_range(0, 3));
      end

      tick(1'b0, 1'b0, 8'h00, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries (power of two).
REQ-002 Parameter TIMEOUT_CYCLES, default 5000000, idle-gap limit while loading (100 ms at 50 MHz).
REQ-003 clk  input  1  sole clock; all logic SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 rx_data  input  8  byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 byte_done  input  1  one-cycle strobe from the programming stage indicating the head byte has been burned.
REQ-008 data_out  output  8  FIFO head byte, fall-through, drives the programming stage data input.
REQ-009 mode  output  1  1 = program, 0 = verify.
REQ-010 en  output  1  enable to the programming stage.
REQ-011 fifo_full / fifo_empty  output  1 each  FIFO status.
REQ-012 err  output  1  sticky error flag, cleared on acceptance of the next valid command byte.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, GET_LEN, LOAD, DRAIN and VERIFY.
REQ-015 IDLE: rx 0x50 -> GET_LEN; rx 0x56 -> VERIFY; any other byte -> err=1, remain in IDLE.
REQ-016 GET_LEN: the next rx byte SHALL load the 9-bit remaining count (0x00 means 256), then the block SHALL enter LOAD.
REQ-017 LOAD: each rx_valid SHALL push rx_data and decrement the count; when the count reaches 0 the block SHALL enter DRAIN in the cycle after the last push.
REQ-018 DRAIN: when fifo_empty=1 the block SHALL return to IDLE on the following cycle.
REQ-019 VERIFY: mode=0, en=1; rx 0x53 -> IDLE; other rx bytes are ignored; FIFO untouched.
REQ-020 In LOAD and DRAIN, mode=1 and en = ~fifo_empty.
REQ-021 byte_done SHALL pop one entry when not empty; byte_done on empty is ignored with no pointer change.
REQ-022 Push when full without a simultaneous pop: byte dropped, count still decremented, err=1.
REQ-023 Push and pop in the same cycle SHALL both succeed at any occupancy, including full, with occupancy unchanged.
REQ-024 Occupancy counter SHALL be log2(DEPTH)+1 bits; pointers SHALL wrap modulo DEPTH.
REQ-025 data_out SHALL equal mem[rd_ptr] combinationally; its value is don't-care when empty.
REQ-026 Timeout counter SHALL clear on every rx_valid and on entry to LOAD, and SHALL increment each LOAD cycle.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES in LOAD: err=1, FIFO flushed, state -> IDLE next cycle.
REQ-028 Outputs SHALL be registered except data_out, fifo_full and fifo_empty, which SHALL be decoded from registers.

Reset
REQ-029 rst=0 at a clock edge: state=IDLE, pointers and occupancy=0, count=0, timeout=0, mode=0, en=0, err=0, busy=0, fifo_empty=1, fifo_full=0.
REQ-030 Reset asserted mid-LOAD or mid-VERIFY SHALL discard all buffered data with no further en assertion.
REQ-031 Memory contents need not be reset.

Verification
REQ-032 Bytes 0x50,0x03,0xA1,0xB2,0xC3, three byte_done pulses -> data_out sequence A1,B2,C3; en drops when empty; IDLE one cycle later.
REQ-033 0x50,0x00, then 256 bytes with byte_done every 4th cycle -> no err, all 256 bytes popped in order.
REQ-034 0x50,0x14, then 20 bytes with no byte_done -> fifo_full after 16; err=1; 4 bytes dropped; DRAIN reached.
REQ-035 0x50,0x05, 2 bytes, then silence for TIMEOUT_CYCLES (bench parameter set to 100) -> err=1, fifo_empty=1, IDLE.
REQ-036 0x56 -> mode=0, en=1, busy=1; 0x53 -> IDLE, en=0; 0x41 in IDLE -> err=1.
REQ-037 rst=0 with 8 bytes buffered -> next cycle fifo_empty=1, en=0, state IDLE.
